// File: rtl/stream_filter.sv
// -----------------------------------------------------------------------------
// stream_filter
//   Valid/ready stream gate. When drop_i is high every upstream beat is
//   accepted and discarded: ready_o is forced high and valid_o is held low.
//   When drop_i is low the stream passes straight through.
//
// Ports
//   valid_i / ready_o : upstream handshake
//   drop_i            : 1 = swallow beats, 0 = pass beats
//   valid_o / ready_i : downstream handshake
// -----------------------------------------------------------------------------
module stream_filter (
    input  logic valid_i,
    output logic ready_o,
    input  logic drop_i,
    output logic valid_o,
    input  logic ready_i
);

    assign valid_o = drop_i ? 1'b0 : valid_i;
    assign ready_o = drop_i ? 1'b1 : ready_i;

endmodule

// File: rtl/stream_skip_ctrl.sv
// -----------------------------------------------------------------------------
// stream_skip_ctrl
//   Command-driven pass/drop controller for a valid/ready stream. Each accepted
//   command either passes or drops (cmd_len_i + 1) upstream beats, then the
//   controller returns to IDLE. A new command can be accepted in the cycle of
//   the final beat, so consecutive commands chain without a bubble.
//
// Ports
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_drop_i              : 1 = drop beats, 0 = pass beats
//   cmd_len_i               : beats in command minus one
//   valid_i / ready_o       : upstream handshake
//   valid_o / ready_i       : downstream handshake
//   busy_o                  : a command is in progress
//   done_o                  : pulses on the final beat of a command
// -----------------------------------------------------------------------------
module stream_skip_ctrl #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_drop_i,
    input  logic [CntWidth-1:0] cmd_len_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    typedef logic [CntWidth-1:0] cnt_t;

    state_e state_q, state_d;
    logic   drop_q,  drop_d;
    cnt_t   len_q,   len_d;
    cnt_t   cnt_q,   cnt_d;

    logic active;
    logic filt_valid_in, filt_ready_in, filt_drop;
    logic beat, last_beat, cmd_hs;

    assign active = (state_q == ACTIVE);

    // In IDLE the filter sees a dead stream, so upstream stalls and nothing
    // reaches downstream regardless of the latched mode.
    assign filt_valid_in = active & valid_i;
    assign filt_ready_in = active & ready_i;
    assign filt_drop     = active ? drop_q : 1'b0;

    stream_filter i_stream_filter (
        .valid_i (filt_valid_in),
        .ready_o (ready_o),
        .drop_i  (filt_drop),
        .valid_o (valid_o),
        .ready_i (filt_ready_in)
    );

    // ready_o is already zero in IDLE; the explicit qualifier keeps intent clear.
    assign beat      = active & valid_i & ready_o;
    assign last_beat = beat & (cnt_q == len_q);

    // Accept a new command while idle, or in the final-beat cycle for chaining.
    assign cmd_ready_o = ~active | last_beat;
    assign cmd_hs      = cmd_valid_i & cmd_ready_o;

    assign busy_o = active;
    assign done_o = last_beat;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (cmd_hs) begin
            state_d = ACTIVE;
            drop_d  = cmd_drop_i;
            len_d   = cmd_len_i;
            cnt_d   = '0;
        end else if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (beat) begin
            // Cannot overflow: the last beat is reached at cnt_q == len_q.
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/stream_skip_ctrl.md
STREAM_SKIP_CTRL -- requirements
Module: stream_skip_ctrl

Interface
REQ-001 Parameter: CntWidth, default 16, width of the beat-count field.
REQ-002 Port: clk_i  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid_i  input  1  command valid.
REQ-005 Port: cmd_ready_o  output  1  command ready.
REQ-006 Port: cmd_drop_i  input  1  command mode: 1 = drop beats, 0 = pass beats.
REQ-007 Port: cmd_len_i  input  CntWidth  number of beats in the command, minus one.
REQ-008 Port: valid_i  input  1  upstream valid.
REQ-009 Port: ready_o  output  1  upstream ready.
REQ-010 Port: valid_o  output  1  downstream valid.
REQ-011 Port: ready_i  input  1  downstream ready.
REQ-012 Port: busy_o  output  1  command in progress.
REQ-013 Port: done_o  output  1  single-cycle pulse on the final beat of a command.

Function
REQ-014 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-015 IDLE SHALL drive cmd_ready_o=1, ready_o=0, valid_o=0 and busy_o=0, so upstream is stalled with no beat passed or dropped.
REQ-016 A command handshake (cmd_valid_i & cmd_ready_o) SHALL latch cmd_drop_i and cmd_len_i, clear the beat counter to 0, and enter ACTIVE on the next edge.
REQ-017 ACTIVE SHALL drive busy_o=1.
REQ-018 In ACTIVE with latched drop=0: valid_o=valid_i and ready_o=ready_i.
REQ-019 In ACTIVE with latched drop=1: valid_o=0 and ready_o=1, independent of ready_i.
REQ-020 A beat SHALL be counted when valid_i & ready_o is true in ACTIVE; the counter SHALL increment by 1 per beat.
REQ-021 The last beat is the counted beat with counter == latched len; it SHALL assert done_o combinationally in that cycle.
REQ-022 On the last beat with no new command accepted, the FSM SHALL return to IDLE.
REQ-023 cmd_ready_o SHALL also be 1 in ACTIVE during the last-beat cycle, giving zero-bubble chaining.
REQ-024 A command accepted in the last-beat cycle SHALL relatch drop and len, clear the counter, and remain in ACTIVE.
REQ-025 cmd_ready_o SHALL be 0 in every other ACTIVE cycle.
REQ-026 cmd_len_i = 0 SHALL mean exactly 1 beat; cmd_len_i = 2^CntWidth-1 SHALL mean 2^CntWidth beats.
REQ-027 The counter SHALL never wrap within a command, because it stops at len.
REQ-028 Outputs SHALL have no combinational path from cmd_valid_i to valid_o or ready_o.
REQ-029 The only combinational paths SHALL be:
  - valid_i/ready_i to valid_o/ready_o/done_o/cmd_ready_o;
  - valid_i/ready_i/cmd_valid_i to next state.

Reset
REQ-030 Asserting rst_i SHALL asynchronously force IDLE, counter=0, latched drop=0 and latched len=0.
REQ-031 During reset, outputs SHALL be cmd_ready_o=1, ready_o=0, valid_o=0, busy_o=0 and done_o=0.
REQ-032 Reset mid-command SHALL abandon the command, with no done_o pulse; the remaining beats are neither passed nor dropped.

Structure
REQ-033 No shared package is required.
REQ-034 The state enum and counter type SHALL be local to the module.
REQ-035 The pass/drop gating SHALL be one instance of the common-cells stream_filter.
REQ-036 The stream_filter drop input SHALL be driven by (state==ACTIVE ? latched drop : 0).
REQ-037 The IDLE stall SHALL be applied outside stream_filter by forcing valid_i and ready_i into it to 0.
REQ-038 Synthesisable RTL target: 120-400 lines.

Verification
REQ-039 Pass command: cmd len=2, drop=0, 3 beats offered, ready_i=1.
  - Response: 3 beats on valid_o; done_o on the 3rd; busy_o=0 next cycle.
REQ-040 Drop command: cmd len=3, drop=1, ready_i held 0, 4 beats offered.
  - Response: ready_o=1 every cycle; valid_o never 1; done_o on the 4th beat.
REQ-041 Back-to-back: cmd (len=0, drop=1) and (len=1, drop=0) both queued.
  - Response: the second command is accepted in the same cycle as the first done_o; busy_o stays 1; no bubble before the pass beats.
REQ-042 Backpressure: pass cmd len=1 with ready_i toggling 0/1 and valid_i held 1.
  - Response: the counter advances only on ready_i=1 cycles; done_o on the 2nd handshake.
REQ-043 Reset mid-op: pass cmd len=5, rst_i asserted after 2 beats.
  - Response: IDLE immediately; busy_o=0; no done_o; the next command counts from 0.
REQ-044 Max length: CntWidth=4, cmd len=15.
  - Response: exactly 16 beats counted before done_o, with no early wrap.
